multdiv_unit: RTL and testbench
===============================

# multdiv_unit

Multicycle signed 32-bit multiplier/divider that answers the processor's execute stage. The processor issues a one-cycle `ctrl_MULT` or `ctrl_DIV` pulse with operands and stalls its X stage until `data_resultRDY`. The unit uses iterative shift-add multiply and restoring non-performing divide, one bit per cycle, with a fixed latency the pipeline's stall logic can rely on.

## Interface
- `WIDTH`, 32: operand/result width; iteration count equals `WIDTH`.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `ctrl_MULT`  in  1  start pulse for multiply; samples operands.
- `ctrl_DIV`  in  1  start pulse for divide; samples operands.
- `data_operandA`  in  WIDTH  multiplicand / dividend, two's complement.
- `data_operandB`  in  WIDTH  multiplier / divisor, two's complement.
- `data_result`  out  WIDTH  product low word or quotient; held after completion.
- `data_exception`  out  1  overflow or divide-by-zero, valid with `data_resultRDY`.
- `data_resultRDY`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while an operation is in flight.

## Operation
- States: IDLE, MULT, DIV, DONE. Iteration counter is 0..WIDTH-1.
- Start is accepted in any state, including mid-operation. A start aborts the current operation, re-latches the operands, clears the counter, and enters MULT or DIV. The aborted operation never produces `data_resultRDY`.
- `ctrl_MULT` and `ctrl_DIV` both high on the same edge: multiply wins.
- MULT:
  - Latch `|A|` and `|B|` plus the result sign (`A[31]^B[31]`).
  - Accumulate the 2*WIDTH-bit unsigned product, one multiplier bit per cycle.
  - At the end, negate if the sign is set.
  - `data_result` = product[WIDTH-1:0].
  - `data_exception` = 1 iff product[2*WIDTH-1:WIDTH-1] is not all-equal, i.e. the result does not fit in signed WIDTH.
- DIV:
  - Unsigned restoring division on `|A|` and `|B|`, one quotient bit per cycle.
  - Quotient negated if `A[31]^B[31]`; truncation is toward zero. The remainder is discarded.
  - B == 0: `data_exception` = 1, `data_result` = 0. The full latency still applies.
  - INT_MIN / -1: `data_result` = 0x80000000, `data_exception` = 0 (wraps).
- After iteration WIDTH-1, enter DONE for exactly one cycle, then IDLE.
- `data_result` and `data_exception` update only on entry to DONE. They hold until the next DONE or reset.
- `busy` = state is MULT or DIV.

## Timing
- Start sampled at rising edge k. `busy` is high from after edge k until edge k+WIDTH.
- `data_resultRDY`, `data_result` and `data_exception` are registered:
  - `data_resultRDY` rises at edge k+WIDTH (k+32 by default) and falls at edge k+WIDTH+1.
- A start at edge j > k during an operation restarts the timing: ready at edge j+WIDTH.
- A start sampled at the same edge DONE is entered still yields that ready pulse. The new operation proceeds with ready at j+WIDTH.
- Reset (`reset` low), asynchronous: state IDLE, counter 0, `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0.
  - Reset mid-operation discards it; no ready pulse follows.
  - Starts are ignored while `reset` is low.
- Operand inputs are don't-care except at the start edge.

## Test plan
- Multiply: A=7, B=-6, `ctrl_MULT` pulse at edge k -> `busy` high k..k+31; at edge k+32 `data_resultRDY`=1 for one cycle, `data_result`=-42 (0xFFFFFFD6), `data_exception`=0.
- Divide signs: A=-100, B=7 -> -14. A=100, B=-7 -> -14. A=-100, B=-7 -> 14. All at k+32, exception 0. A=0x80000000, B=-1 -> 0x80000000, exception 0.
- Exceptions:
  - A=5, B=0 via `ctrl_DIV` -> RDY at k+32, result 0, exception 1.
  - A=0x10000, B=0x10000 via `ctrl_MULT` -> result 0, exception 1.
  - A=0x7FFFFFFF, B=1 -> result 0x7FFFFFFF, exception 0.
- Restart: `ctrl_MULT` (3*4) at edge k, then `ctrl_DIV` (20/3) at edge k+10 -> no RDY at k+32; exactly one RDY at k+42 with result 6.
- Simultaneous starts: `ctrl_MULT`=`ctrl_DIV`=1 with A=9, B=3 -> result 27.
- Reset:
  - Assert `reset` low between edges during a divide (edge k+15) -> outputs 0 immediately; no RDY in the following 40 cycles.
  - After release, a fresh multiply completes normally at +32.

Source files
------------

// File: rtl/multdiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface multdiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  // Processor side: issues start pulses and operands, consumes results.
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  // Unit side.
  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier / restoring divider, one bit per cycle, fixed WIDTH-cycle latency.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  multdiv_unit_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Multiply has priority when both start pulses arrive together.
  logic start_mult, start_div;
  assign start_mult = bus.ctrl_MULT;
  assign start_div  = bus.ctrl_DIV & ~bus.ctrl_MULT;

  logic [2*WIDTH-1:0] mcand_q, prod_q;
  logic [WIDTH-1:0]   mplier_q, quot_q, rem_q, divisor_q;
  logic               neg_q, div0_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  // One iteration of each algorithm; the final iteration feeds the result regs directly.
  logic [2*WIDTH-1:0] prod_step, prod_signed;
  logic [WIDTH:0]     rem_shift, rem_diff, prod_top;
  logic               q_bit, mult_ovf;
  logic [WIDTH-1:0]   rem_step, quot_step, quot_signed;

  assign prod_step   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign prod_signed = neg_q ? -prod_step : prod_step;
  assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
  assign mult_ovf    = ~((&prod_top) | ~(|prod_top));

  // Borrow out of the trial subtraction means the divisor did not fit.
  assign rem_shift   = {rem_q, quot_q[WIDTH-1]};
  assign rem_diff    = rem_shift - {1'b0, divisor_q};
  assign q_bit       = ~rem_diff[WIDTH];
  assign rem_step    = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quot_step   = {quot_q[WIDTH-2:0], q_bit};
  assign quot_signed = neg_q ? -quot_step : quot_step;

  logic             busy, last_iter, rdy_d, exc_d, rdy_q, exc_q;
  logic [WIDTH-1:0] result_d, result_q;

  // State register and iteration counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a start always wins and restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start_mult) begin
      state_d = StMult;
      cnt_d   = '0;
    end else if (start_div) begin
      state_d = StDiv;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StMult, StDiv: begin
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs: the finishing iteration loads the result even if a new start arrives with it.
  always_comb begin
    busy      = (state_q == StMult) || (state_q == StDiv);
    last_iter = busy && (cnt_q == LastCnt);
    rdy_d     = last_iter;
    result_d  = result_q;
    exc_d     = exc_q;
    if (last_iter) begin
      if (state_q == StMult) begin
        result_d = prod_signed[WIDTH-1:0];
        exc_d    = mult_ovf;
      end else if (div0_q) begin
        result_d = '0;
        exc_d    = 1'b1;
      end else begin
        result_d = quot_signed;
        exc_d    = 1'b0;
      end
    end
  end

  // Operand latch on start, then one shift/add or shift/subtract step per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q   <= '0;
      prod_q    <= '0;
      mplier_q  <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      neg_q     <= 1'b0;
      div0_q    <= 1'b0;
    end else if (start_mult || start_div) begin
      mcand_q   <= {{WIDTH{1'b0}}, abs_a};
      prod_q    <= '0;
      mplier_q  <= abs_b;
      quot_q    <= abs_a;
      rem_q     <= '0;
      divisor_q <= abs_b;
      neg_q     <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      div0_q    <= (bus.data_operandB == '0);
    end else if (state_q == StMult) begin
      prod_q   <= prod_step;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
    end else if (state_q == StDiv) begin
      rem_q  <= rem_step;
      quot_q <= quot_step;
    end
  end

  // Registered result, exception and ready pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy;
endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed corner cases plus randomized operations against a signed model.
module tb_multdiv_unit;
  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multdiv_unit_if #(.WIDTH(W)) bus ();
  multdiv_unit #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Reference: plain signed arithmetic on wide integers.
  function automatic void model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic exc);
    longint      p;
    logic [63:0] pv;
    int          q;
    if (is_mult) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      pv  = p;
      res = pv[31:0];
      exc = (p != longint'($signed(pv[31:0])));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b0;
    end else begin
      q   = int'($signed(a)) / int'($signed(b));
      res = q;
      exc = 1'b0;
    end
  endfunction

  // Drive a one-cycle start; returns at the negedge just after the sampling edge.
  task automatic start_pulse(input logic m, input logic d, input logic [31:0] a,
                             input logic [31:0] b);
    @(negedge clk);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clk);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Watch n cycles; busy is expected high for cycles 1..busy_until-1.
  task automatic observe(input int n, input int busy_until, output int lat, output int rdys,
                         output int busy_bad, output logic [31:0] res, output logic exc);
    lat = -1; rdys = 0; busy_bad = 0; res = 'x; exc = 1'bx;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.data_resultRDY === 1'b1) begin
        rdys++;
        if (lat < 0) begin
          lat = i;
          res = bus.data_result;
          exc = bus.data_exception;
        end
      end
      if (bus.busy !== (i < busy_until)) busy_bad++;
    end
  endtask

  task automatic test_reset();
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0; bus.data_operandB = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.data_result !== 32'd0) $display("FAIL reset_result got %h want 0", bus.data_result); else passed++;
    checks++; if (bus.data_exception !== 1'b0) $display("FAIL reset_exc got %b want 0", bus.data_exception); else passed++;
    checks++; if (bus.data_resultRDY !== 1'b0) $display("FAIL reset_rdy got %b want 0", bus.data_resultRDY); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic        tm[9], td[9], te[9];
    logic [31:0] ta[9], tb[9], tr[9];
    int lat, rdys, bb;
    logic [31:0] res;
    logic exc;
    tm = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    td = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ta = '{32'd7, -32'd100, 32'd100, -32'd100, 32'h8000_0000, 32'd5, 32'h1_0000,
           32'h7FFF_FFFF, 32'h8000_0000};
    tb = '{-32'd6, 32'd7, -32'd7, -32'd7, 32'hFFFF_FFFF, 32'd0, 32'h1_0000, 32'd1, 32'd1};
    tr = '{32'hFFFF_FFD6, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14, 32'h8000_0000, 32'd0, 32'd0,
           32'h7FFF_FFFF, 32'h8000_0000};
    te = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int v = 0; v < 9; v++) begin
      start_pulse(tm[v], td[v], ta[v], tb[v]);
      checks++; if (bus.busy !== 1'b1) $display("FAIL dir%0d_busy0 got %b want 1", v, bus.busy); else passed++;
      observe(40, 32, lat, rdys, bb, res, exc);
      checks++; if (lat !== 32) $display("FAIL dir%0d_lat got %0d want 32", v, lat); else passed++;
      checks++; if (rdys !== 1) $display("FAIL dir%0d_rdycount got %0d want 1", v, rdys); else passed++;
      checks++; if (bb !== 0) $display("FAIL dir%0d_busy got %0d bad cycles want 0", v, bb); else passed++;
      checks++; if (res !== tr[v]) $display("FAIL dir%0d_result got %h want %h", v, res, tr[v]); else passed++;
      checks++; if (exc !== te[v]) $display("FAIL dir%0d_exc got %b want %b", v, exc, te[v]); else passed++;
    end
  endtask

  task automatic test_restart();
    int lat, rdys, bb;
    logic [31:0] res;
    logic exc;
    start_pulse(1'b1, 1'b0, 32'd3, 32'd4);
    observe(8, 32, lat, rdys, bb, res, exc);
    start_pulse(1'b0, 1'b1, 32'd20, 32'd3);
    observe(40, 32, lat, rdys, bb, res, exc);
    checks++; if (lat !== 32) $display("FAIL restart_lat got %0d want 32", lat); else passed++;
    checks++; if (rdys !== 1) $display("FAIL restart_rdycount got %0d want 1", rdys); else passed++;
    checks++; if (res !== 32'd6) $display("FAIL restart_result got %h want 6", res); else passed++;
    checks++; if (bb !== 0) $display("FAIL restart_busy got %0d bad cycles want 0", bb); else passed++;
  endtask

  task automatic test_simultaneous();
    int lat, rdys, bb;
    logic [31:0] res;
    logic exc;
    start_pulse(1'b1, 1'b1, 32'd9, 32'd3);
    observe(40, 32, lat, rdys, bb, res, exc);
    checks++; if (lat !== 32) $display("FAIL simul_lat got %0d want 32", lat); else passed++;
    checks++; if (res !== 32'd27) $display("FAIL simul_result got %h want 27", res); else passed++;
    checks++; if (exc !== 1'b0) $display("FAIL simul_exc got %b want 0", exc); else passed++;
  endtask

  task automatic test_start_at_done();
    int lat, rdys, bb;
    logic [31:0] res;
    logic exc;
    start_pulse(1'b1, 1'b0, 32'd7, -32'd6);
    observe(30, 32, lat, rdys, bb, res, exc);
    start_pulse(1'b0, 1'b1, -32'd100, 32'd7);
    checks++; if (bus.data_resultRDY !== 1'b1) $display("FAIL atdone_rdy got %b want 1", bus.data_resultRDY); else passed++;
    checks++; if (bus.data_result !== 32'hFFFF_FFD6) $display("FAIL atdone_result got %h want ffffffd6", bus.data_result); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL atdone_busy got %b want 1", bus.busy); else passed++;
    observe(40, 32, lat, rdys, bb, res, exc);
    checks++; if (lat !== 32) $display("FAIL atdone_next_lat got %0d want 32", lat); else passed++;
    checks++; if (res !== 32'hFFFF_FFF2) $display("FAIL atdone_next_result got %h want fffffff2", res); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat, rdys, bb;
    logic [31:0] res;
    logic exc;
    start_pulse(1'b0, 1'b1, -32'd100, 32'd7);
    observe(15, 99, lat, rdys, bb, res, exc);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.data_result !== 32'd0) $display("FAIL rstmid_result got %h want 0", bus.data_result); else passed++;
    checks++; if (bus.data_exception !== 1'b0) $display("FAIL rstmid_exc got %b want 0", bus.data_exception); else passed++;
    checks++; if (bus.data_resultRDY !== 1'b0) $display("FAIL rstmid_rdy got %b want 0", bus.data_resultRDY); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bus.busy); else passed++;
    // A start presented while reset is held must be ignored.
    @(negedge clk);
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd3;
    repeat (2) @(negedge clk);
    bus.ctrl_MULT = 1'b0;
    rst_n = 1'b1;
    observe(40, 0, lat, rdys, bb, res, exc);
    checks++; if (rdys !== 0) $display("FAIL rstmid_norrdy got %0d want 0", rdys); else passed++;
    checks++; if (bb !== 0) $display("FAIL rstmid_idle_busy got %0d bad cycles want 0", bb); else passed++;
    start_pulse(1'b1, 1'b0, -32'd12, -32'd11);
    observe(40, 32, lat, rdys, bb, res, exc);
    checks++; if (lat !== 32) $display("FAIL rstmid_fresh_lat got %0d want 32", lat); else passed++;
    checks++; if (res !== 32'd132) $display("FAIL rstmid_fresh_result got %h want 84", res); else passed++;
  endtask

  task automatic test_random();
    int lat, rdys, bb;
    logic [31:0] res, a, b, er;
    logic exc, ee, m;
    for (int n = 0; n < 24; n++) begin
      m = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: begin
          a = $urandom_range(0, 2000) - 1000;
          b = $urandom_range(0, 60) - 30;
        end
        2: b = 32'd0;
        default: begin
          a = 32'h8000_0000;
          b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : ($urandom_range(0, 4) - 2);
        end
      endcase
      model(m, a, b, er, ee);
      start_pulse(m, ~m, a, b);
      observe(40, 32, lat, rdys, bb, res, exc);
      checks++; if (lat !== 32) $display("FAIL rnd%0d_lat got %0d want 32", n, lat); else passed++;
      checks++; if (res !== er) $display("FAIL rnd%0d_result %s a=%h b=%h got %h want %h", n, m ? "mul" : "div", a, b, res, er); else passed++;
      checks++; if (exc !== ee) $display("FAIL rnd%0d_exc %s a=%h b=%h got %b want %b", n, m ? "mul" : "div", a, b, exc, ee); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart();
    test_simultaneous();
    test_start_at_done();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
